// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: synchronise, debounce, then emit press/release/long-press/repeat strobes.
// The release strobe port is named `rel` because `release` is a reserved word in SystemVerilog.

module btn_conditioner #(
  parameter int N_CH            = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] rpt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic          PIN_INV   = (ACTIVE_LOW != 0);
  localparam logic          REPEAT_ON = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_HELD      = 2'd1,
    ST_REPEATING = 2'd2
  } state_t;

  genvar ch;
  for (ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [DW-1:0]          deb_cnt_r, deb_cnt_nxt_s;
    logic                   level_r, toggle_s;
    state_t                 state_r, state_nxt_s;
    logic [HW-1:0]          hold_cnt_r, hold_cnt_nxt_s;
    logic [RW-1:0]          rpt_cnt_r, rpt_cnt_nxt_s;
    logic                   press_r, press_nxt_s;
    logic                   rel_r, rel_nxt_s;
    logic                   long_r, long_nxt_s;
    logic                   rpt_r, rpt_nxt_s;

    // Synchroniser chain for the raw, optionally inverted pin
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in[ch] ^ PIN_INV};
      end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Stable-time counter; toggle_s marks the edge on which level flips
    always_comb begin
      deb_cnt_nxt_s = deb_cnt_r;
      toggle_s      = 1'b0;
      if (sync_s == level_r) begin
        deb_cnt_nxt_s = {DW{1'b0}};
      end else if (deb_cnt_r == DEB_LAST) begin
        toggle_s      = 1'b1;
        deb_cnt_nxt_s = {DW{1'b0}};
      end else begin
        deb_cnt_nxt_s = deb_cnt_r + DW'(1'b1);
      end
    end

    // Event FSM: strobes are decided from toggle_s so press/rel line up with the new level
    always_comb begin
      state_nxt_s    = state_r;
      hold_cnt_nxt_s = hold_cnt_r;
      rpt_cnt_nxt_s  = rpt_cnt_r;
      press_nxt_s    = 1'b0;
      rel_nxt_s      = 1'b0;
      long_nxt_s     = 1'b0;
      rpt_nxt_s      = 1'b0;
      case (state_r)
        ST_RELEASED: begin
          if (toggle_s && !level_r) begin
            state_nxt_s    = ST_HELD;
            press_nxt_s    = 1'b1;
            hold_cnt_nxt_s = {HW{1'b0}};
          end else begin
            state_nxt_s = ST_RELEASED;
          end
        end
        ST_HELD: begin
          if (toggle_s && level_r) begin
            state_nxt_s    = ST_RELEASED;
            rel_nxt_s      = 1'b1;
            hold_cnt_nxt_s = {HW{1'b0}};
          end else if (hold_cnt_r == HOLD_MAX) begin
            hold_cnt_nxt_s = HOLD_MAX;
          end else if (hold_cnt_r == HOLD_LAST) begin
            long_nxt_s     = 1'b1;
            hold_cnt_nxt_s = HOLD_MAX;
            if (REPEAT_ON) begin
              state_nxt_s   = ST_REPEATING;
              rpt_cnt_nxt_s = {RW{1'b0}};
            end else begin
              state_nxt_s = ST_HELD;
            end
          end else begin
            hold_cnt_nxt_s = hold_cnt_r + HW'(1'b1);
          end
        end
        ST_REPEATING: begin
          if (toggle_s && level_r) begin
            state_nxt_s   = ST_RELEASED;
            rel_nxt_s     = 1'b1;
            rpt_cnt_nxt_s = {RW{1'b0}};
          end else if (rpt_cnt_r == RPT_LAST) begin
            rpt_nxt_s     = 1'b1;
            rpt_cnt_nxt_s = {RW{1'b0}};
          end else begin
            rpt_cnt_nxt_s = rpt_cnt_r + RW'(1'b1);
          end
        end
        default: begin
          state_nxt_s    = ST_RELEASED;
          hold_cnt_nxt_s = {HW{1'b0}};
          rpt_cnt_nxt_s  = {RW{1'b0}};
        end
      endcase
    end

    // Channel state, counters and registered strobes
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_cnt_r  <= {DW{1'b0}};
        level_r    <= 1'b0;
        state_r    <= ST_RELEASED;
        hold_cnt_r <= {HW{1'b0}};
        rpt_cnt_r  <= {RW{1'b0}};
        press_r    <= 1'b0;
        rel_r      <= 1'b0;
        long_r     <= 1'b0;
        rpt_r      <= 1'b0;
      end else begin
        deb_cnt_r  <= deb_cnt_nxt_s;
        level_r    <= level_r ^ toggle_s;
        state_r    <= state_nxt_s;
        hold_cnt_r <= hold_cnt_nxt_s;
        rpt_cnt_r  <= rpt_cnt_nxt_s;
        press_r    <= press_nxt_s;
        rel_r      <= rel_nxt_s;
        long_r     <= long_nxt_s;
        rpt_r      <= rpt_nxt_s;
      end
    end

    assign level[ch]      = level_r;
    assign press[ch]      = press_r;
    assign rel[ch]        = rel_r;
    assign long_press[ch] = long_r;
    assign rpt[ch]        = rpt_r;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random pins, checked against a timestamp-based model.
// Lanes 0-1 are the active-high instance, lanes 2-3 the active-low instance.

module tb_btn_conditioner;
  localparam int N    = 2;
  localparam int SS   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int RPT  = 8;

  logic clk, rst;
  logic [N-1:0] btn_a, btn_b;
  logic [N-1:0] a_level, a_press, a_rel, a_long, a_rpt;
  logic [N-1:0] b_level, b_press, b_rel, b_long, b_rpt;
  logic [19:0] obs_v, exp_v;
  logic [3:0]  m_level, m_press, m_rel, m_long, m_rpt;
  int n_cmp, n_bad;

  btn_conditioner #(.N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
                    .REPEAT_CYCLES(RPT), .REPEAT_EN(1), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_a), .level(a_level), .press(a_press),
    .rel(a_rel), .long_press(a_long), .rpt(a_rpt));

  btn_conditioner #(.N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
                    .REPEAT_CYCLES(RPT), .REPEAT_EN(1), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .btn_in(btn_b), .level(b_level), .press(b_press),
    .rel(b_rel), .long_press(b_long), .rpt(b_rpt));

  assign obs_v = {b_rpt, b_long, b_rel, b_press, b_level, a_rpt, a_long, a_rel, a_press, a_level};
  assign exp_v = {m_rpt[3:2], m_long[3:2], m_rel[3:2], m_press[3:2], m_level[3:2],
                  m_rpt[1:0], m_long[1:0], m_rel[1:0], m_press[1:0], m_level[1:0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: sync is the logical pin delayed SS edges; level flips once the last DEB sync
  // samples all disagree with it; long/rpt follow from the age since the press.
  initial begin : model
    logic       hist [4][SS];
    logic       win  [4][DEB];
    int         press_t [4];
    int         cyc, age;
    logic       sync_v, all_diff;
    logic [3:0] raw_v;
    cyc = 0;
    m_level = 4'h0; m_press = 4'h0; m_rel = 4'h0; m_long = 4'h0; m_rpt = 4'h0;
    for (int l = 0; l < 4; l++) begin
      press_t[l] = 0;
      for (int j = 0; j < SS; j++) hist[l][j] = 1'b0;
      for (int j = 0; j < DEB; j++) win[l][j] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_level = 4'h0; m_press = 4'h0; m_rel = 4'h0; m_long = 4'h0; m_rpt = 4'h0;
        for (int l = 0; l < 4; l++) begin
          for (int j = 0; j < SS; j++) hist[l][j] = 1'b0;
          for (int j = 0; j < DEB; j++) win[l][j] = 1'b0;
        end
      end else begin
        cyc++;
        raw_v = {~btn_b, btn_a};
        for (int l = 0; l < 4; l++) begin
          sync_v = hist[l][SS-1];
          for (int j = SS - 1; j > 0; j--) hist[l][j] = hist[l][j-1];
          hist[l][0] = raw_v[l];
          for (int j = DEB - 1; j > 0; j--) win[l][j] = win[l][j-1];
          win[l][0] = sync_v;
          all_diff = 1'b1;
          for (int j = 0; j < DEB; j++) if (win[l][j] == m_level[l]) all_diff = 1'b0;
          m_press[l] = 1'b0; m_rel[l] = 1'b0; m_long[l] = 1'b0; m_rpt[l] = 1'b0;
          if (all_diff) begin
            m_level[l] = ~m_level[l];
            if (m_level[l]) begin
              m_press[l] = 1'b1;
              press_t[l] = cyc;
            end else begin
              m_rel[l] = 1'b1;
            end
          end else if (m_level[l]) begin
            age = cyc - press_t[l];
            if (age == HOLD) m_long[l] = 1'b1;
            else if (age > HOLD && (age - HOLD) % RPT == 0) m_rpt[l] = 1'b1;
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; btn_a = 2'b00; btn_b = 2'b11;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_v !== 20'h0) begin n_bad++; $display("FAIL reset_outputs obs=%h exp=%h", obs_v, 20'h0); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL reset_idle obs=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  task automatic test_press;
    btn_a[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      n_cmp++;
      if (a_press[0] !== (e == 6)) begin n_bad++; $display("FAIL press_latency e=%0d obs=%b exp=%b", e, a_press[0], e == 6); end
      n_cmp++;
      if (a_level[0] !== (e >= 6)) begin n_bad++; $display("FAIL press_level e=%0d obs=%b exp=%b", e, a_level[0], e >= 6); end
      n_cmp++;
      if ({a_level[1], a_press[1], a_rel[1], a_long[1], a_rpt[1]} !== 5'b0) begin
        n_bad++; $display("FAIL press_ch1_quiet e=%0d obs=%b exp=00000", e, {a_level[1], a_press[1], a_rel[1], a_long[1], a_rpt[1]});
      end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL press_model obs=%h exp=%h", obs_v, exp_v); end
    end
    btn_a[0] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      n_cmp++;
      if (a_rel[0] !== (e == 6)) begin n_bad++; $display("FAIL release_latency e=%0d obs=%b exp=%b", e, a_rel[0], e == 6); end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL release_model obs=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  task automatic test_bounce;
    logic [5:0] pat;
    pat = 6'b101101;
    for (int i = 0; i < 5; i++) begin
      btn_a[0] = pat[i];
      @(negedge clk);
      n_cmp++;
      if (a_press[0] !== 1'b0) begin n_bad++; $display("FAIL bounce_quiet i=%0d obs=%b exp=0", i, a_press[0]); end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL bounce_model obs=%h exp=%h", obs_v, exp_v); end
    end
    btn_a[0] = pat[5];
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      n_cmp++;
      if (a_press[0] !== (e == 6)) begin n_bad++; $display("FAIL bounce_press e=%0d obs=%b exp=%b", e, a_press[0], e == 6); end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL bounce_model obs=%h exp=%h", obs_v, exp_v); end
    end
    btn_a[0] = 1'b0;
    repeat (10) begin
      @(negedge clk); n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL bounce_rel_model obs=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  task automatic test_hold;
    logic found;
    btn_a[0] = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 12 && !found; w++) begin
      @(negedge clk);
      if (a_press[0] === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin n_bad++; $display("FAIL hold_press_timeout obs=%b exp=1", found); end
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      n_cmp++;
      if (a_long[0] !== (k == HOLD)) begin n_bad++; $display("FAIL hold_long k=%0d obs=%b exp=%b", k, a_long[0], k == HOLD); end
      n_cmp++;
      if (a_rpt[0] !== (k > HOLD && (k - HOLD) % RPT == 0)) begin
        n_bad++; $display("FAIL hold_rpt k=%0d obs=%b exp=%b", k, a_rpt[0], k > HOLD && (k - HOLD) % RPT == 0);
      end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL hold_model obs=%h exp=%h", obs_v, exp_v); end
    end
    btn_a[0] = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_rel[0], a_long[0], a_rpt[0]} !== {e == 6, 1'b0, 1'b0}) begin
        n_bad++; $display("FAIL hold_release e=%0d obs=%b exp=%b", e, {a_rel[0], a_long[0], a_rpt[0]}, {e == 6, 1'b0, 1'b0});
      end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL hold_rel_model obs=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  task automatic test_early_release;
    logic found;
    for (int d = 13; d <= 14; d++) begin
      btn_a[0] = 1'b1;
      found = 1'b0;
      for (int w = 0; w < 12 && !found; w++) begin
        @(negedge clk);
        if (a_press[0] === 1'b1) found = 1'b1;
      end
      n_cmp++;
      if (found !== 1'b1) begin n_bad++; $display("FAIL early_press_timeout obs=%b exp=1", found); end
      for (int k = 1; k <= d; k++) begin
        @(negedge clk); n_cmp++;
        if (obs_v !== exp_v) begin n_bad++; $display("FAIL early_model obs=%h exp=%h", obs_v, exp_v); end
      end
      btn_a[0] = 1'b0;
      for (int k = d + 1; k <= d + 14; k++) begin
        @(negedge clk);
        n_cmp++;
        if ({a_rel[0], a_long[0]} !== {k == d + 6, 1'b0}) begin
          n_bad++; $display("FAIL early_release d=%0d k=%0d obs=%b exp=%b", d, k, {a_rel[0], a_long[0]}, {k == d + 6, 1'b0});
        end
        n_cmp++;
        if (obs_v !== exp_v) begin n_bad++; $display("FAIL early_model obs=%h exp=%h", obs_v, exp_v); end
      end
    end
  endtask

  task automatic test_active_low;
    rst = 1'b1; btn_b = 2'b11;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs_v !== 20'h0) begin n_bad++; $display("FAIL al_reset obs=%h exp=%h", obs_v, 20'h0); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (b_press !== 2'b00) begin n_bad++; $display("FAIL al_no_press obs=%b exp=00", b_press); end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL al_model obs=%h exp=%h", obs_v, exp_v); end
    end
    btn_b[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({b_press[0], b_level[0]} !== {e == 6, e >= 6}) begin
        n_bad++; $display("FAIL al_press e=%0d obs=%b exp=%b", e, {b_press[0], b_level[0]}, {e == 6, e >= 6});
      end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL al_model obs=%h exp=%h", obs_v, exp_v); end
    end
    btn_b[0] = 1'b1;
    repeat (10) begin
      @(negedge clk); n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL al_rel_model obs=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  task automatic test_reset_mid;
    logic found;
    btn_a[0] = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 12 && !found; w++) begin
      @(negedge clk);
      if (a_press[0] === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin n_bad++; $display("FAIL midrst_press_timeout obs=%b exp=1", found); end
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk); n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL midrst_model obs=%h exp=%h", obs_v, exp_v); end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs_v !== 20'h0) begin n_bad++; $display("FAIL midrst_async_clear obs=%h exp=%h", obs_v, 20'h0); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 28; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_press[0], a_long[0]} !== {e == 6, e == 6 + HOLD}) begin
        n_bad++; $display("FAIL midrst_repress e=%0d obs=%b exp=%b", e, {a_press[0], a_long[0]}, {e == 6, e == 6 + HOLD});
      end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL midrst_model obs=%h exp=%h", obs_v, exp_v); end
    end
    btn_a[0] = 1'b0;
    repeat (12) begin
      @(negedge clk); n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL midrst_rel_model obs=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  task automatic test_random;
    int         cnt [4];
    logic [3:0] lv;
    lv = 4'h0;
    for (int l = 0; l < 4; l++) cnt[l] = 5;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL random_model c=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      for (int l = 0; l < 4; l++) begin
        if (cnt[l] == 0) begin
          lv[l] = ~lv[l];
          cnt[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 70);
        end else begin
          cnt[l]--;
        end
      end
      btn_a = lv[1:0];
      btn_b = ~lv[3:2];
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    btn_a = 2'b00; btn_b = 2'b11;
    repeat (12) begin
      @(negedge clk); n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL random_tail obs=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; btn_a = 2'b00; btn_b = 2'b11;
    test_reset();
    test_press();
    test_bounce();
    test_hold();
    test_early_release();
    test_active_low();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
